eoi_rotation_controller: RTL and testbench

EOI_ROTATION_CONTROLLER -- requirements
Module: eoi_rotation_controller

---
 rtl/eoi_rotation_controller.sv | 170 +++++++++++++++++
 tb/tb_eoi_rotation_controller.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eoi_rotation_controller.sv
// eoi_rotation_controller
//
// End-of-interrupt and priority-rotation control for a programmable interrupt
// controller. Decodes OCW2 commands (non-specific / specific EOI, rotation,
// set-priority, rotate-in-AEOI mode), generates automatic EOI at the end of an
// INTA sequence, and tracks the current lowest-priority level.
//
// Ports
//   clock                          in   single clock, rising edge
//   reset                          in   synchronous, active-high
//   write_initial_command_word_1   in   ICW1 strobe (soft initialisation)
//   write_operation_control_word_2 in   OCW2 strobe, edge-detected
//   internal_data_bus[7:0]         in   OCW2 byte {R, SL, EOI, level[4:0]}
//   highest_level_in_service[N]    in   one-hot highest in-service level
//   auto_eoi_config                in   AEOI mode
//   end_of_acknowledge_sequence    in   pulse at end of INTA sequence
//   acknowledge_interrupt[N]       in   one-hot level just acknowledged
//   end_of_interrupt[N]            out  one-hot ISR clear, one-cycle pulse
//   auto_rotate_mode               out  rotate-in-AEOI flag
//   priority_rotate[LEVEL_BITS]    out  index of lowest-priority level
//   eoi_error                      out  sticky error (only with EOI_ERROR_FLAG_EN)
//
// Build option: define EOI_ERROR_FLAG_EN to add the eoi_error port and logic.

module eoi_rotation_controller #(
  parameter  int NUM_LEVELS = 8,
  localparam int LEVEL_BITS = $clog2(NUM_LEVELS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_initial_command_word_1,
  input  logic                  write_operation_control_word_2,
  input  logic [7:0]            internal_data_bus,
  input  logic [NUM_LEVELS-1:0] highest_level_in_service,
  input  logic                  auto_eoi_config,
  input  logic                  end_of_acknowledge_sequence,
  input  logic [NUM_LEVELS-1:0] acknowledge_interrupt,
  output logic [NUM_LEVELS-1:0] end_of_interrupt,
  output logic                  auto_rotate_mode,
  output logic [LEVEL_BITS-1:0] priority_rotate
`ifdef EOI_ERROR_FLAG_EN
  ,
  output logic                  eoi_error
`endif
);

  localparam logic [LEVEL_BITS-1:0] LOWEST_DEFAULT = LEVEL_BITS'(NUM_LEVELS - 1);

  logic [NUM_LEVELS-1:0] eoi_q, eoi_d;
  logic                  arm_q, arm_d;
  logic [LEVEL_BITS-1:0] rot_q, rot_d;
  logic                  ocw2_prev_q;

  logic                  ocw2_edge;
  logic [2:0]            cmd;
  logic [LEVEL_BITS-1:0] level;
  logic [NUM_LEVELS-1:0] level_onehot;
  logic [LEVEL_BITS-1:0] isr_idx;
  logic [LEVEL_BITS-1:0] ack_idx;
  logic                  isr_any;
  logic                  aeoi_hit;

  // Bits above the level field only matter for error reporting.
  logic unused_bus_bits;
  assign unused_bus_bits = ^internal_data_bus[4:0];

  assign ocw2_edge    = write_operation_control_word_2 & ~ocw2_prev_q;
  assign cmd          = internal_data_bus[7:5];
  assign level        = internal_data_bus[LEVEL_BITS-1:0];
  assign level_onehot = NUM_LEVELS'(1) << level;
  assign isr_any      = |highest_level_in_service;
  assign aeoi_hit     = auto_eoi_config & end_of_acknowledge_sequence
                        & (|acknowledge_interrupt);

  // Inputs are one-hot; a plain scan yields the index of the set bit.
  always_comb begin
    isr_idx = '0;
    ack_idx = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (highest_level_in_service[i]) isr_idx = LEVEL_BITS'(i);
      if (acknowledge_interrupt[i])    ack_idx = LEVEL_BITS'(i);
    end
  end

`ifdef EOI_ERROR_FLAG_EN
  logic       err_q, err_d;
  logic [4:0] upper_bits;
  // Shifting (instead of slicing) keeps this legal when LEVEL_BITS == 5.
  assign upper_bits = internal_data_bus[4:0] >> LEVEL_BITS;
`endif

  always_comb begin
    eoi_d = '0;
    arm_d = arm_q;
    rot_d = rot_q;
`ifdef EOI_ERROR_FLAG_EN
    err_d = err_q;
`endif

    // AEOI first so that an OCW2 rotation in the same cycle overrides it.
    if (aeoi_hit) begin
      eoi_d = acknowledge_interrupt;
      if (arm_q) rot_d = ack_idx;
    end

    if (ocw2_edge) begin
`ifdef EOI_ERROR_FLAG_EN
      if (upper_bits != 5'd0) err_d = 1'b1;
      if ((cmd == 3'b001 || cmd == 3'b101) && !isr_any) err_d = 1'b1;
`endif
      unique case (cmd)
        3'b001: eoi_d = eoi_d | highest_level_in_service;
        3'b011: eoi_d = eoi_d | level_onehot;
        3'b101: begin
          if (isr_any) begin
            eoi_d = eoi_d | highest_level_in_service;
            rot_d = isr_idx;
          end
        end
        3'b111: begin
          eoi_d = eoi_d | level_onehot;
          rot_d = level;
        end
        3'b110: rot_d = level;
        3'b100: arm_d = 1'b1;
        3'b000: arm_d = 1'b0;
        default: ;
      endcase
    end

    // Soft initialisation discards anything decoded in the same cycle.
    if (write_initial_command_word_1) begin
      eoi_d = '0;
      arm_d = 1'b0;
      rot_d = LOWEST_DEFAULT;
`ifdef EOI_ERROR_FLAG_EN
      err_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      eoi_q       <= '0;
      arm_q       <= 1'b0;
      rot_q       <= LOWEST_DEFAULT;
      // A strobe already high when reset releases must not count as an edge.
      ocw2_prev_q <= 1'b1;
`ifdef EOI_ERROR_FLAG_EN
      err_q       <= 1'b0;
`endif
    end else begin
      eoi_q       <= eoi_d;
      arm_q       <= arm_d;
      rot_q       <= rot_d;
      ocw2_prev_q <= write_operation_control_word_2;
`ifdef EOI_ERROR_FLAG_EN
      err_q       <= err_d;
`endif
    end
  end

  assign end_of_interrupt = eoi_q;
  assign auto_rotate_mode = arm_q;
  assign priority_rotate  = rot_q;
`ifdef EOI_ERROR_FLAG_EN
  assign eoi_error        = err_q;
`endif

endmodule

// File: tb/tb_eoi_rotation_controller.sv
module tb_eoi_rotation_controller;

  logic clock;
  int   checks = 0;
  int   errors = 0;

  // 8-level instance
  logic       reset, icw1, ocw2, aeoi, eoa;
  logic [7:0] bus, hlis, ack;
  logic [7:0] eoi;
  logic       arm;
  logic [2:0] pr;
  logic       err_out;

  // 32-level instance
  logic        reset_w, icw1_w, ocw2_w, aeoi_w, eoa_w;
  logic [7:0]  bus_w;
  logic [31:0] hlis_w, ack_w, eoi_w;
  logic        arm_w;
  logic [4:0]  pr_w;
  logic        err_out_w;

`ifdef EOI_ERROR_FLAG_EN
  logic eoi_error, eoi_error_w;
  assign err_out   = eoi_error;
  assign err_out_w = eoi_error_w;
`else
  assign err_out   = 1'b0;
  assign err_out_w = 1'b0;
`endif

  eoi_rotation_controller #(.NUM_LEVELS(8)) dut (
    .clock                          (clock),
    .reset                          (reset),
    .write_initial_command_word_1   (icw1),
    .write_operation_control_word_2 (ocw2),
    .internal_data_bus              (bus),
    .highest_level_in_service       (hlis),
    .auto_eoi_config                (aeoi),
    .end_of_acknowledge_sequence    (eoa),
    .acknowledge_interrupt          (ack),
    .end_of_interrupt               (eoi),
    .auto_rotate_mode               (arm),
    .priority_rotate                (pr)
`ifdef EOI_ERROR_FLAG_EN
    ,.eoi_error                     (eoi_error)
`endif
  );

  eoi_rotation_controller #(.NUM_LEVELS(32)) dut_w (
    .clock                          (clock),
    .reset                          (reset_w),
    .write_initial_command_word_1   (icw1_w),
    .write_operation_control_word_2 (ocw2_w),
    .internal_data_bus              (bus_w),
    .highest_level_in_service       (hlis_w),
    .auto_eoi_config                (aeoi_w),
    .end_of_acknowledge_sequence    (eoa_w),
    .acknowledge_interrupt          (ack_w),
    .end_of_interrupt               (eoi_w),
    .auto_rotate_mode               (arm_w),
    .priority_rotate                (pr_w)
`ifdef EOI_ERROR_FLAG_EN
    ,.eoi_error                     (eoi_error_w)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_err(input string name, input logic act, input logic exp);
`ifdef EOI_ERROR_FLAG_EN
    check(name, longint'(act), longint'(exp));
`endif
  endtask

  typedef struct {
    bit       icw1, ocw2;
    bit [7:0] bus, hlis;
    bit       aeoi, eoa;
    bit [7:0] ack;
    bit [7:0] x_eoi;
    bit       x_arm;
    bit [2:0] x_pr;
    bit       x_err;
  } vec_t;

  // Reference model: state after one clock given the inputs before it.
  typedef struct {
    int unsigned eoi;
    bit          arm;
    int unsigned pr;
    bit          err;
    bit          prev;
  } mstate_t;

  function automatic mstate_t model_step(mstate_t s, int unsigned n, bit rst, bit i1,
                                         bit o2, int unsigned b, int unsigned hl,
                                         bit ae, bit ea, int unsigned ak);
    mstate_t     m = s;
    int unsigned lvl, hi;
    m.prev = o2;
    if (rst) begin
      m.eoi = 0; m.arm = 0; m.pr = n - 1; m.err = 0; m.prev = 1;
      return m;
    end
    if (i1) begin
      m.eoi = 0; m.arm = 0; m.pr = n - 1; m.err = 0;
      return m;
    end
    m.eoi = 0;
    if (ae && ea && ak != 0) begin
      m.eoi = ak;
      if (s.arm) m.pr = $clog2(ak);
    end
    if (o2 && !s.prev) begin
      lvl = (b % 32) % n;
      hi  = (b % 32) / n;
      if (hi != 0) m.err = 1;
      case (b / 32)
        1: begin m.eoi |= hl; if (hl == 0) m.err = 1; end
        3: m.eoi |= (32'd1 << lvl);
        5: begin
          if (hl != 0) begin m.eoi |= hl; m.pr = $clog2(hl); end
          else m.err = 1;
        end
        7: begin m.eoi |= (32'd1 << lvl); m.pr = lvl; end
        6: m.pr = lvl;
        4: m.arm = 1;
        0: m.arm = 0;
        default: ;
      endcase
    end
    return m;
  endfunction

  vec_t    tbl[$];
  mstate_t ms;
  int      pulses;

  initial begin
    reset = 1; icw1 = 0; ocw2 = 0; bus = 0; hlis = 0; aeoi = 0; eoa = 0; ack = 0;
    reset_w = 1; icw1_w = 0; ocw2_w = 0; bus_w = 0; hlis_w = 0; aeoi_w = 0; eoa_w = 0; ack_w = 0;
    step(); step();
    check("reset_eoi", eoi, 0);
    check("reset_arm", arm, 0);
    check("reset_pr", pr, 7);
    check_err("reset_err", err_out, 0);
    reset = 0; reset_w = 0;
    step();

    // Held strobe: exactly one non-specific EOI pulse, no rotation.
    pulses = 0;
    ocw2 = 1; bus = 8'h20; hlis = 8'h08;
    for (int i = 0; i < 10; i++) begin
      step();
      if (eoi == 8'h08) pulses++;
      else check("held_idle_eoi", eoi, 0);
    end
    check("held_pulse_count", pulses, 1);
    check("held_pr", pr, 7);
    ocw2 = 0; hlis = 0;
    step();

    //              icw1 ocw2 bus    hlis   ae eoa ack    x_eoi  arm pr err
    tbl.push_back(vec_t'{1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 7, 0});
    tbl.push_back(vec_t'{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 7, 0});
    tbl.push_back(vec_t'{0, 1, 8'h60, 8'h00, 0, 0, 8'h00, 8'h01, 0, 7, 0});
    tbl.push_back(vec_t'{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 7, 0});
    tbl.push_back(vec_t'{0, 1, 8'hE3, 8'h00, 0, 0, 8'h00, 8'h08, 0, 3, 0});
    tbl.push_back(vec_t'{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 3, 0});
    tbl.push_back(vec_t'{0, 1, 8'hC5, 8'h00, 0, 0, 8'h00, 8'h00, 0, 5, 0});
    tbl.push_back(vec_t'{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 5, 0});
    tbl.push_back(vec_t'{0, 1, 8'h80, 8'h00, 0, 0, 8'h00, 8'h00, 1, 5, 0});
    tbl.push_back(vec_t'{0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'h10, 1, 4, 0});
    tbl.push_back(vec_t'{0, 1, 8'h62, 8'h00, 1, 1, 8'h10, 8'h14, 1, 4, 0});
    tbl.push_back(vec_t'{0, 0, 8'h00, 8'h00, 1, 1, 8'h01, 8'h01, 1, 0, 0});
    tbl.push_back(vec_t'{0, 1, 8'hE6, 8'h00, 1, 1, 8'h01, 8'h41, 1, 6, 0});
    tbl.push_back(vec_t'{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 6, 0});
    tbl.push_back(vec_t'{0, 1, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 6, 0});
    tbl.push_back(vec_t'{0, 0, 8'h00, 8'h00, 1, 1, 8'h02, 8'h02, 0, 6, 0});
    tbl.push_back(vec_t'{0, 1, 8'h40, 8'h08, 0, 0, 8'h00, 8'h00, 0, 6, 0});
    tbl.push_back(vec_t'{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 6, 0});
    tbl.push_back(vec_t'{0, 1, 8'hA0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 6, 1});
    tbl.push_back(vec_t'{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 6, 1});
    tbl.push_back(vec_t'{1, 1, 8'hC1, 8'h00, 0, 0, 8'h00, 8'h00, 0, 7, 0});
    tbl.push_back(vec_t'{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 7, 0});
    tbl.push_back(vec_t'{0, 1, 8'hA0, 8'h20, 0, 0, 8'h00, 8'h20, 0, 5, 0});
    tbl.push_back(vec_t'{0, 0, 8'h00, 8'h00, 1, 0, 8'h04, 8'h00, 0, 5, 0});
    tbl.push_back(vec_t'{0, 1, 8'h38, 8'h02, 0, 0, 8'h00, 8'h02, 0, 5, 1});
    tbl.push_back(vec_t'{1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 7, 0});

    foreach (tbl[i]) begin
      icw1 = tbl[i].icw1; ocw2 = tbl[i].ocw2; bus = tbl[i].bus; hlis = tbl[i].hlis;
      aeoi = tbl[i].aeoi; eoa = tbl[i].eoa; ack = tbl[i].ack;
      step();
      check($sformatf("tbl%0d_eoi", i), eoi, tbl[i].x_eoi);
      check($sformatf("tbl%0d_arm", i), arm, tbl[i].x_arm);
      check($sformatf("tbl%0d_pr", i), pr, tbl[i].x_pr);
      check_err($sformatf("tbl%0d_err", i), err_out, tbl[i].x_err);
    end
    icw1 = 0; ocw2 = 0; bus = 0; hlis = 0; aeoi = 0; eoa = 0; ack = 0;
    step();

    // Reset during a pulse, with the strobe still high on release.
    ocw2 = 1; bus = 8'hE3;
    step();
    check("midrst_pulse", eoi, 8'h08);
    check("midrst_pr_before", pr, 3);
    reset = 1;
    step();
    check("midrst_eoi", eoi, 0);
    check("midrst_pr", pr, 7);
    check("midrst_arm", arm, 0);
    reset = 0;
    step();
    check("rst_release_no_edge", eoi, 0);
    check("rst_release_pr", pr, 7);
    ocw2 = 0;
    step();

    // 32-level instance.
    ocw2_w = 1; bus_w = 8'hC2;
    step();
    check("w_setprio_pr", pr_w, 2);
    ocw2_w = 0;
    step();
    ocw2_w = 1; bus_w = 8'hFF;
    step();
    check("w_ff_eoi", eoi_w, 32'h8000_0000);
    check("w_ff_pr", pr_w, 31);
    check_err("w_ff_err", err_out_w, 0);
    ocw2_w = 0;
    step();
    ocw2_w = 1; bus_w = 8'h80;
    step();
    ocw2_w = 0;
    step();
    check("w_arm", arm_w, 1);
    ocw2_w = 1; bus_w = 8'hE4;
    step();
    check("w_e4_eoi", eoi_w, 32'h0000_0010);
    check("w_e4_pr", pr_w, 4);
    reset_w = 1;
    step();
    check("w_midrst_eoi", eoi_w, 0);
    check("w_midrst_pr", pr_w, 31);
    check("w_midrst_arm", arm_w, 0);
    check_err("w_midrst_err", err_out_w, 0);
    reset_w = 0; ocw2_w = 0;
    step();

    // Randomised run against the reference model.
    icw1 = 1; ocw2 = 0;
    step();
    ms = '{eoi: 0, arm: 0, pr: 7, err: 0, prev: 0};
    icw1 = 0;
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      icw1  = ($urandom_range(0, 31) == 0);
      ocw2  = $urandom_range(0, 1);
      bus   = 8'($urandom);
      hlis  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
      aeoi  = $urandom_range(0, 1);
      eoa   = ($urandom_range(0, 3) == 0);
      ack   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
      ms = model_step(ms, 8, reset, icw1, ocw2, bus, hlis, aeoi, eoa, ack);
      step();
      check($sformatf("rnd%0d_eoi", c), eoi, ms.eoi);
      check($sformatf("rnd%0d_arm", c), arm, ms.arm);
      check($sformatf("rnd%0d_pr", c), pr, ms.pr);
      check_err($sformatf("rnd%0d_err", c), err_out, ms.err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
